// File: rtl/dram_pkg.sv
// Shared types and constants for the RAS/MUX/CAS DRAM responder.
package dram_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ROW_OPEN   = 2'd1,
        COL_ACTIVE = 2'd2,
        ERR_WAIT   = 2'd3
    } state_e;

    localparam int ERR_CNT_W = 8;

    // Width of the multiplexed address bus: wide enough for either phase.
    function automatic int max_w(input int row_bits, input int col_bits);
        return (row_bits > col_bits) ? row_bits : col_bits;
    endfunction

endpackage

// File: rtl/dram_if.sv
// Controller-to-DRAM strobe/address/data bundle; the controller is master.
interface dram_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
);
    logic              ras_in;
    logic              cas_in;
    logic              mux_in;
    logic [ADDR_W-1:0] addr_in;
    logic              we_n_in;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid_out;
    logic              err_out;
    logic [ERR_W-1:0]  err_count_out;

    modport master (
        output ras_in, cas_in, mux_in, addr_in, we_n_in, data_in,
        input  data_out, data_valid_out, err_out, err_count_out
    );

    modport slave (
        input  ras_in, cas_in, mux_in, addr_in, we_n_in, data_in,
        output data_out, data_valid_out, err_out, err_count_out
    );
endinterface

// File: rtl/dram_array.sv
// Single-port storage array: synchronous write, registered synchronous read.
module dram_array #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk_in) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register holds its value between reads.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rdata <= {DW{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dram_responder.sv
// DRAM-side responder: decodes RAS/CAS strobes, enforces tRCD/tRP, counts violations.
module dram_responder
    import dram_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4,
    parameter int DATA_W   = 8,
    parameter int T_RCD    = 2,
    parameter int T_RP     = 2
) (
    input  logic  clk_in,
    input  logic  rst_n_in,
    dram_if.slave bus
);
    localparam int ADDR_W = max_w(ROW_BITS, COL_BITS);
    localparam int ARR_AW = ROW_BITS + COL_BITS;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] TRCD_MIN = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0] TRP_MIN  = CNT_W'(T_RP);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    localparam logic [1:0] S_IDLE       = IDLE;
    localparam logic [1:0] S_ROW_OPEN   = ROW_OPEN;
    localparam logic [1:0] S_COL_ACTIVE = COL_ACTIVE;
    localparam logic [1:0] S_ERR_WAIT   = ERR_WAIT;

    logic [1:0]           r_state,    w_state_nxt;
    logic [CNT_W-1:0]     r_trp_cnt,  w_trp_nxt,  w_trp_inc;
    logic [CNT_W-1:0]     r_trcd_cnt, w_trcd_nxt, w_trcd_inc;
    logic [ROW_BITS-1:0]  r_row,      w_row_nxt;
    logic [COL_BITS-1:0]  r_col,      w_col_nxt;
    logic                 r_valid,    w_valid_nxt;
    logic                 r_err,      w_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_we, w_re;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_rdata;

    assign w_addr     = bus.addr_in;
    assign w_trp_inc  = (r_trp_cnt  >= TRP_MIN)  ? r_trp_cnt  : r_trp_cnt  + 8'd1;
    assign w_trcd_inc = (r_trcd_cnt >= TRCD_MIN) ? r_trcd_cnt : r_trcd_cnt + 8'd1;

    // Next-state, counter, access and error decode.
    always_comb begin
        w_state_nxt = r_state;
        w_trp_nxt   = r_trp_cnt;
        w_trcd_nxt  = r_trcd_cnt;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_valid_nxt = r_valid;
        w_err       = 1'b0;
        w_we        = 1'b0;
        w_re        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ras_in) begin
                    w_trp_nxt = w_trp_inc;
                    w_err     = ~bus.cas_in;
                end else if ((r_trp_cnt >= TRP_MIN) && !bus.mux_in) begin
                    w_row_nxt   = w_addr[ROW_BITS-1:0];
                    w_trcd_nxt  = 8'd0;
                    w_state_nxt = S_ROW_OPEN;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = S_ERR_WAIT;
                end
            end
            S_ROW_OPEN: begin
                if (bus.ras_in) begin
                    w_trp_nxt   = 8'd1;
                    w_state_nxt = S_IDLE;
                end else begin
                    // Latency is judged on cycles elapsed including this edge.
                    w_trcd_nxt = w_trcd_inc;
                    if (!bus.cas_in) begin
                        if (bus.mux_in && (w_trcd_inc >= TRCD_MIN)) begin
                            w_col_nxt   = w_addr[COL_BITS-1:0];
                            w_we        = ~bus.we_n_in;
                            w_re        = bus.we_n_in;
                            w_valid_nxt = bus.we_n_in;
                            w_state_nxt = S_COL_ACTIVE;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = S_ERR_WAIT;
                        end
                    end else begin
                        w_state_nxt = S_ROW_OPEN;
                    end
                end
            end
            S_COL_ACTIVE: begin
                if (bus.ras_in) begin
                    w_valid_nxt = 1'b0;
                    w_trp_nxt   = 8'd1;
                    w_state_nxt = S_IDLE;
                end else if (bus.cas_in) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_ROW_OPEN;
                end else begin
                    w_state_nxt = S_COL_ACTIVE;
                end
            end
            S_ERR_WAIT: begin
                if (bus.ras_in && bus.cas_in) begin
                    w_trp_nxt   = 8'd1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ERR_WAIT;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and control registers; tRP starts saturated so activate is legal at once.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_trp_cnt  <= TRP_MIN;
            r_trcd_cnt <= 8'd0;
            r_row      <= {ROW_BITS{1'b0}};
            r_col      <= {COL_BITS{1'b0}};
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= {ERR_CNT_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_trp_cnt  <= w_trp_nxt;
            r_trcd_cnt <= w_trcd_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_valid    <= w_valid_nxt;
            r_err      <= w_err;
            if (w_err && (r_err_cnt != ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    dram_array #(
        .AW (ARR_AW),
        .DW (DATA_W)
    ) u_array (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_we     (w_we),
        .i_re     (w_re),
        .i_addr   ({r_row, w_col_nxt}),
        .i_wdata  (bus.data_in),
        .o_rdata  (w_rdata)
    );

    assign bus.data_out       = w_rdata;
    assign bus.data_valid_out = r_valid;
    assign bus.err_out        = r_err;
    assign bus.err_count_out  = r_err_cnt;
endmodule
